// File: rtl/text_console_pkg.sv
`default_nettype none
// ============================================================================
// Module      : text_console_pkg
// Description : Shared constants, control codes and state encoding for the
//               80x25 text console write-side sequencer.
//               Contents: screen geometry (COLS, ROWS, SCREEN_CELLS), fill
//               byte (BLANK_CHAR), control codes (CH_*), state type state_e.
//               The optional TAB state is only reached when the design is
//               built with TEXT_CONSOLE_TAB_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
package text_console_pkg;

    localparam int          COLS         = 80;
    localparam int          ROWS         = 25;
    localparam int          SCREEN_CELLS = COLS * ROWS;
    localparam logic [7:0]  BLANK_CHAR   = 8'h20;

    localparam logic [7:0]  CH_BS  = 8'h08;
    localparam logic [7:0]  CH_TAB = 8'h09;
    localparam logic [7:0]  CH_LF  = 8'h0A;
    localparam logic [7:0]  CH_FF  = 8'h0C;
    localparam logic [7:0]  CH_CR  = 8'h0D;

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_CLEAR  = 2'd1;
    localparam logic [1:0]  ST_SCROLL = 2'd2;
    localparam logic [1:0]  ST_TAB    = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        CLEAR  = ST_CLEAR,
        SCROLL = ST_SCROLL,
        TAB    = ST_TAB
    } state_e;

endpackage : text_console_pkg
`default_nettype wire

// File: rtl/text_console_addr.sv
`default_nettype none
// ============================================================================
// Module      : text_console_addr
// Description : Combinational (row, col, scroll_row) -> text RAM address.
//               phys_row = (scroll_row + row) mod ROWS, done as a single
//               compare-and-subtract (both operands are < ROWS).
//               address  = phys_row * COLS + col, 11 bits.
// Ports       : i_row        logical row (0..ROWS-1)
//               i_col        column (0..COLS-1)
//               i_scroll_row physical row shown as screen row 0
//               o_address    text RAM address
// Revision    : 1.0 - initial release
// ============================================================================
module text_console_addr #(
    parameter int COLS = text_console_pkg::COLS,
    parameter int ROWS = text_console_pkg::ROWS
) (
    input  logic [4:0]  i_row,
    input  logic [6:0]  i_col,
    input  logic [4:0]  i_scroll_row,
    output logic [10:0] o_address
);
    import text_console_pkg::*;

    logic [5:0] w_sum;
    logic [5:0] w_phys;

    assign w_sum     = {1'b0, i_row} + {1'b0, i_scroll_row};
    assign w_phys    = (w_sum >= 6'(ROWS)) ? (w_sum - 6'(ROWS)) : w_sum;
    assign o_address = 11'(w_phys) * 11'(COLS) + 11'(i_col);

endmodule : text_console_addr
`default_nettype wire

// File: rtl/text_console_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : text_console_ctrl
// Description : Write-side sequencer for the 80x25 text display RAM.
//               Takes a byte stream over valid/ready, decodes printable
//               characters and control codes, tracks the cursor and drives
//               the RAM write port. Implements clear-screen (FF, reset) and
//               hardware scrolling through a circular row offset.
//               Optional macro TEXT_CONSOLE_TAB_EN adds TAB (0x09) handling.
// Ports       : clk, reset                 clock, sync active-high reset
//               char_data/valid/ready      input byte handshake
//               write_address/data/en      text RAM write port (registered)
//               scroll_row                 physical row shown as screen row 0
//               cursor_col, cursor_row     logical cursor position
// Revision    : 1.0 - initial release
// ============================================================================
module text_console_ctrl #(
    parameter int         COLS       = text_console_pkg::COLS,
    parameter int         ROWS       = text_console_pkg::ROWS,
    parameter logic [7:0] BLANK_CHAR = text_console_pkg::BLANK_CHAR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  char_data,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [10:0] write_address,
    output logic [7:0]  write_data,
    output logic        write_en,
    output logic [4:0]  scroll_row,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row
);
    import text_console_pkg::*;

    localparam logic [10:0] c_last_cell = 11'(COLS * ROWS - 1);
    localparam logic [10:0] c_last_fill = 11'(COLS - 1);
    localparam logic [6:0]  c_last_col  = 7'(COLS - 1);
    localparam logic [4:0]  c_last_row  = 5'(ROWS - 1);

    state_e      r_state;
    logic [6:0]  r_col;
    logic [4:0]  r_row;
    logic [4:0]  r_scroll;
    logic [10:0] r_fill;
    logic [10:0] r_wr_addr;
    logic [7:0]  r_wr_data;
    logic        r_wr_en;

    logic [4:0]  w_a_row;
    logic [6:0]  w_a_col;
    logic [10:0] w_addr;
    logic [6:0]  w_col_inc;
    logic        w_at_last_col;
    logic        w_printable;
    logic [4:0]  w_nl_row;
    logic [4:0]  w_nl_scroll;
    state_e      w_nl_state;

    // During SCROLL the cleared row is logical row ROWS-1 under the already
    // advanced scroll offset, i.e. the old scroll_row physical row.
    always_comb begin
        w_a_row = r_row;
        w_a_col = r_col;
        if (r_state == SCROLL) begin
            w_a_row = c_last_row;
            w_a_col = r_fill[6:0];
        end
    end

    text_console_addr #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_addr (
        .i_row        (w_a_row),
        .i_col        (w_a_col),
        .i_scroll_row (r_scroll),
        .o_address    (w_addr)
    );

    assign w_col_inc     = r_col + 7'd1;
    assign w_at_last_col = (r_col == c_last_col);
    assign w_printable   = (char_data >= 8'h20) && (char_data <= 8'h7E);

    // Newline outcome: move down, or at the bottom advance the offset and
    // blank the newly exposed row.
    always_comb begin
        w_nl_row    = r_row + 5'd1;
        w_nl_scroll = r_scroll;
        w_nl_state  = IDLE;
        if (r_row == c_last_row) begin
            w_nl_row    = r_row;
            w_nl_scroll = (r_scroll == c_last_row) ? 5'd0 : (r_scroll + 5'd1);
            w_nl_state  = SCROLL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= CLEAR;
            r_col     <= '0;
            r_row     <= '0;
            r_scroll  <= '0;
            r_fill    <= '0;
            r_wr_addr <= '0;
            r_wr_data <= BLANK_CHAR;
            r_wr_en   <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                CLEAR: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_fill;
                    r_wr_data <= BLANK_CHAR;
                    if (r_fill == c_last_cell) begin
                        r_state  <= IDLE;
                        r_fill   <= '0;
                        r_col    <= '0;
                        r_row    <= '0;
                        r_scroll <= '0;
                    end else begin
                        r_fill <= r_fill + 11'd1;
                    end
                end

                SCROLL: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= w_addr;
                    r_wr_data <= BLANK_CHAR;
                    if (r_fill == c_last_fill) begin
                        r_state <= IDLE;
                        r_fill  <= '0;
                    end else begin
                        r_fill <= r_fill + 11'd1;
                    end
                end

`ifdef TEXT_CONSOLE_TAB_EN
                TAB: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= w_addr;
                    r_wr_data <= BLANK_CHAR;
                    if (w_at_last_col) begin
                        r_col    <= '0;
                        r_row    <= w_nl_row;
                        r_scroll <= w_nl_scroll;
                        r_state  <= w_nl_state;
                    end else begin
                        r_col <= w_col_inc;
                        if (w_col_inc[2:0] == 3'd0) begin
                            r_state <= IDLE;
                        end
                    end
                end
`endif

                IDLE: begin
                    if (char_valid && char_ready) begin
                        case (char_data)
                            CH_LF: begin
                                r_col    <= '0;
                                r_row    <= w_nl_row;
                                r_scroll <= w_nl_scroll;
                                r_state  <= w_nl_state;
                            end
                            CH_CR: r_col <= '0;
                            CH_BS: begin
                                if (r_col != 7'd0) begin
                                    r_col <= r_col - 7'd1;
                                end
                            end
                            CH_FF: begin
                                r_state <= CLEAR;
                                r_fill  <= '0;
                            end
`ifdef TEXT_CONSOLE_TAB_EN
                            CH_TAB: r_state <= TAB;
`endif
                            default: begin
                                if (w_printable) begin
                                    r_wr_en   <= 1'b1;
                                    r_wr_addr <= w_addr;
                                    r_wr_data <= char_data;
                                    if (w_at_last_col) begin
                                        r_col    <= '0;
                                        r_row    <= w_nl_row;
                                        r_scroll <= w_nl_scroll;
                                        r_state  <= w_nl_state;
                                    end else begin
                                        r_col <= w_col_inc;
                                    end
                                end
                            end
                        endcase
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign char_ready    = (r_state == IDLE) && !reset;
    assign write_address = r_wr_addr;
    assign write_data    = r_wr_data;
    assign write_en      = r_wr_en;
    assign scroll_row    = r_scroll;
    assign cursor_col    = r_col;
    assign cursor_row    = r_row;

endmodule : text_console_ctrl
`default_nettype wire

// File: tb/tb_text_console_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_console_ctrl
// Description : Directed self-checking bench for text_console_ctrl.
//               Logs every RAM write (cycle, char_ready, address, data) and
//               compares against hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_console_ctrl;

    logic        clk;
    logic        reset;
    logic [7:0]  char_data;
    logic        char_valid;
    logic        char_ready;
    logic [10:0] write_address;
    logic [7:0]  write_data;
    logic        write_en;
    logic [4:0]  scroll_row;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;

    text_console_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .char_data     (char_data),
        .char_valid    (char_valid),
        .char_ready    (char_ready),
        .write_address (write_address),
        .write_data    (write_data),
        .write_en      (write_en),
        .scroll_row    (scroll_row),
        .cursor_col    (cursor_col),
        .cursor_row    (cursor_row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        rdy;
        logic [10:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t wq[$];
    int  cyc    = 0;
    int  n_cmp  = 0;
    int  n_err  = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (write_en === 1'b1) begin
            wr_t e;
            e.cyc = cyc;
            e.rdy = char_ready;
            e.a   = write_address;
            e.d   = write_data;
            wq.push_back(e);
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_char(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (char_ready !== 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk("send_ready", char_ready, 1);
        char_data  = b;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        char_data  = 8'h00;
    endtask

    task automatic send_n(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) send_char(b);
    endtask

    task automatic wait_ready(input string tag, input int max_cyc);
        int n = 0;
        @(negedge clk);
        while (char_ready !== 1'b1 && n < max_cyc) begin
            n++;
            @(negedge clk);
        end
        chk(tag, char_ready, 1);
        settle(2);
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [10:0] a, input logic [7:0] d);
        if (idx < wq.size()) begin
            chk({tag, "_addr"}, wq[idx].a, a);
            chk({tag, "_data"}, wq[idx].d, d);
        end else begin
            chk({tag, "_missing"}, wq.size(), idx + 1);
        end
    endtask

    task automatic check_clear(input string tag);
        int bad = 0;
        chk({tag, "_count"}, wq.size(), 2000);
        for (int i = 0; i < wq.size(); i++) begin
            if (wq[i].a !== 11'(i) || wq[i].d !== 8'h20) bad++;
        end
        chk({tag, "_seq_bad"}, bad, 0);
        if (wq.size() >= 1999) chk({tag, "_ready_low_in_fill"}, wq[1998].rdy, 0);
        chk({tag, "_ready_after"}, char_ready, 1);
        chk({tag, "_we_after"}, write_en, 0);
        chk({tag, "_col"}, cursor_col, 0);
        chk({tag, "_row"}, cursor_row, 0);
        chk({tag, "_scroll"}, scroll_row, 0);
    endtask

    initial begin
        int n;
        int bad;
        reset      = 1'b1;
        char_valid = 1'b0;
        char_data  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_we", write_en, 0);
        chk("rst_ready", char_ready, 0);
        chk("rst_addr", write_address, 0);
        chk("rst_data", write_data, 8'h20);
        chk("rst_scroll", scroll_row, 0);
        chk("rst_col", cursor_col, 0);
        chk("rst_row", cursor_row, 0);
        wq.delete();
        reset = 1'b0;
        wait_ready("boot_ready", 2200);
        check_clear("boot");

        // 'A','B' at origin
        wq.delete();
        send_char(8'h41);
        send_char(8'h42);
        settle(3);
        chk("ab_count", wq.size(), 2);
        chk_wr("ab_0", 0, 11'd0, 8'h41);
        chk_wr("ab_1", 1, 11'd1, 8'h42);
        chk("ab_col", cursor_col, 2);
        chk("ab_row", cursor_row, 0);

        // 24 LF then 'X' lands on row 24
        wq.delete();
        send_n(8'h0A, 24);
        send_char(8'h58);
        settle(3);
        chk("x_count", wq.size(), 1);
        chk_wr("x", 0, 11'd1920, 8'h58);
        chk("x_row", cursor_row, 24);
        chk("x_col", cursor_col, 1);

        // LF at bottom row: scroll
        wq.delete();
        send_char(8'h0A);
        n = 0;
        @(negedge clk);
        while (char_ready !== 1'b1 && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("scroll_ready_low_cycles", n, 80);
        settle(2);
        chk("scroll_count", wq.size(), 80);
        bad = 0;
        for (int i = 0; i < wq.size(); i++) begin
            if (wq[i].a !== 11'(i) || wq[i].d !== 8'h20) bad++;
        end
        chk("scroll_seq_bad", bad, 0);
        chk("scroll_row_out", scroll_row, 1);
        chk("scroll_cur_row", cursor_row, 24);
        chk("scroll_cur_col", cursor_col, 0);
        wq.delete();
        send_char(8'h59);
        settle(3);
        chk_wr("y", 0, 11'd0, 8'h59);

        // CR / BS boundaries
        send_char(8'h0D);
        settle(1);
        chk("cr_col1", cursor_col, 0);
        send_char(8'h08);
        settle(1);
        chk("bs_col0", cursor_col, 0);
        chk("bs_col0_row", cursor_row, 24);
        send_n(8'h61, 37);
        settle(1);
        chk("a37_col", cursor_col, 37);
        send_char(8'h08);
        settle(1);
        chk("bs_col37", cursor_col, 36);
        settle(2);
        wq.delete();
        send_char(8'h5A);
        settle(3);
        chk_wr("z_overwrite", 0, 11'd36, 8'h5A);
        chk("z_col", cursor_col, 37);
        send_char(8'h0D);
        settle(1);
        chk("cr_col37", cursor_col, 0);
        chk("cr_row", cursor_row, 24);

        // Form feed clears everything
        settle(2);
        wq.delete();
        send_char(8'h0C);
        wait_ready("ff_ready", 2200);
        check_clear("ff");

        // Row wrap at col 79
        wq.delete();
        send_n(8'h77, 80);
        settle(3);
        chk("wrap_count", wq.size(), 80);
        chk_wr("wrap_last", 79, 11'd79, 8'h77);
        chk("wrap_col", cursor_col, 0);
        chk("wrap_row", cursor_row, 1);

        // Printable at (79,24): char write then 80 scroll writes, no gap
        send_n(8'h0A, 23);
        send_n(8'h65, 79);
        settle(2);
        chk("corner_pre_col", cursor_col, 79);
        chk("corner_pre_row", cursor_row, 24);
        wq.delete();
        send_char(8'h45);
        wait_ready("corner_ready", 300);
        chk("corner_count", wq.size(), 81);
        chk_wr("corner_char", 0, 11'd1999, 8'h45);
        bad = 0;
        for (int k = 1; k < wq.size(); k++) begin
            if (wq[k].a !== 11'(k - 1) || wq[k].d !== 8'h20 || wq[k].cyc != wq[0].cyc + k) bad++;
        end
        chk("corner_scroll_bad", bad, 0);
        chk("corner_scroll_row", scroll_row, 1);
        chk("corner_col", cursor_col, 0);
        chk("corner_row", cursor_row, 24);

        // TAB from col 3
        send_char(8'h0D);
        send_n(8'h71, 3);
        settle(2);
        chk("tab_pre_col", cursor_col, 3);
        wq.delete();
        send_char(8'h09);
        wait_ready("tab_ready", 100);
`ifdef TEXT_CONSOLE_TAB_EN
        chk("tab_count", wq.size(), 5);
        bad = 0;
        for (int i = 0; i < wq.size(); i++) begin
            if (wq[i].a !== 11'(3 + i) || wq[i].d !== 8'h20) bad++;
        end
        chk("tab_seq_bad", bad, 0);
        chk("tab_col", cursor_col, 8);
`else
        chk("tab_ignored_count", wq.size(), 0);
        chk("tab_ignored_col", cursor_col, 3);
`endif

        // Reset in the middle of a clear
        send_char(8'h0C);
        settle(100);
        chk("midfill_we", write_en, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_we", write_en, 0);
        chk("midrst_ready", char_ready, 0);
        chk("midrst_scroll", scroll_row, 0);
        chk("midrst_row", cursor_row, 0);
        wq.delete();
        reset = 1'b0;
        wait_ready("midrst_ready_end", 2200);
        check_clear("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_text_console_ctrl
`default_nettype wire
